// File: rtl/button_conditioner.sv
// Push-button front end: synchronizes raw active-low buttons, debounces each
// channel with a counter FSM, and emits a clean level plus press/release pulses.
module button_conditioner #(
    parameter int N_BTN           = 4,
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic [N_BTN-1:0] Btn_n,
    output logic [N_BTN-1:0] Btn_Level,
    output logic [N_BTN-1:0] Btn_Press,
    output logic [N_BTN-1:0] Btn_Release,
    output logic             Any_Press
);

    typedef enum logic [1:0] {
        IDLE,
        PRESS_WAIT,
        HELD,
        REL_WAIT
    } state_t;

    localparam int                CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    // Synchronizer chain; stage 0 captures the inverted (active-high) raw level.
    logic [SYNC_STAGES-1:0][N_BTN-1:0] sync_q;
    logic [N_BTN-1:0]                  s;

    // NOTE: sequential state uses non-blocking assignments so every flop samples
    // the pre-edge value of its neighbours, which is what makes the shift work.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], ~Btn_n};
        end
    end

    assign s = sync_q[SYNC_STAGES-1];

    // Per-channel next-value vectors, registered into the outputs below.
    logic [N_BTN-1:0] level_nx;
    logic [N_BTN-1:0] press_nx;
    logic [N_BTN-1:0] rel_nx;

    for (genvar g = 0; g < N_BTN; g++) begin : g_ch
        state_t           state_q;
        state_t           state_d;
        logic [CNT_W-1:0] cnt_q;
        logic [CNT_W-1:0] cnt_d;
        logic             level_d;
        logic             press_d;
        logic             rel_d;

        always_ff @(posedge Clk or negedge Reset) begin
            if (!Reset) begin
                state_q <= IDLE;
                cnt_q   <= '0;
            end else begin
                state_q <= state_d;
                cnt_q   <= cnt_d;
            end
        end

        // NOTE: every output of this block gets a default first, so no path
        // through the case statement can leave a value unassigned (no latch).
        always_comb begin
            state_d = state_q;
            cnt_d   = cnt_q;
            level_d = Btn_Level[g];
            press_d = 1'b0;
            rel_d   = 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (s[g]) begin
                        state_d = PRESS_WAIT;
                        cnt_d   = '0;
                    end
                end
                PRESS_WAIT: begin
                    if (!s[g]) begin
                        state_d = IDLE;
                        cnt_d   = '0;
                    end else if (cnt_q == CNT_LAST) begin
                        state_d = HELD;
                        cnt_d   = '0;
                        level_d = 1'b1;
                        press_d = 1'b1;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                HELD: begin
                    if (!s[g]) begin
                        state_d = REL_WAIT;
                        cnt_d   = '0;
                    end
                end
                REL_WAIT: begin
                    if (s[g]) begin
                        // Bounce during release: back to held, nothing reported.
                        state_d = HELD;
                        cnt_d   = '0;
                    end else if (cnt_q == CNT_LAST) begin
                        state_d = IDLE;
                        cnt_d   = '0;
                        level_d = 1'b0;
                        rel_d   = 1'b1;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                default: begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end
            endcase
        end

        assign level_nx[g] = level_d;
        assign press_nx[g] = press_d;
        assign rel_nx[g]   = rel_d;
    end

    // Registered outputs; Any_Press is computed from the same next-press
    // vector so it lands in the same cycle as Btn_Press.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            Btn_Level   <= '0;
            Btn_Press   <= '0;
            Btn_Release <= '0;
            Any_Press   <= 1'b0;
        end else begin
            Btn_Level   <= level_nx;
            Btn_Press   <= press_nx;
            Btn_Release <= rel_nx;
            Any_Press   <= |press_nx;
        end
    end

endmodule

// File: doc/button_conditioner.md
Name: button_conditioner

Overview:
- Upstream input-conditioning stage for the logic processor's push buttons (Reset/LoadA/LoadB/Execute).
- Per button: synchronizes the raw active-low level to Clk, debounces it with a per-channel counter FSM, and outputs a clean active-high level plus single-cycle press and release pulses.
- Outputs feed the processor's button inputs and control FSM directly; no further synchronizer is needed downstream.

Parameters:
- N_BTN, 4, number of independent button channels.
- SYNC_STAGES, 2, synchronizer flop depth (min 2).
- DEBOUNCE_CYCLES, 4, consecutive stable cycles required to accept a change (min 1; 500000 on board, 4 in simulation).

Ports:
- Clk  in  1  system clock, all state on its rising edge.
- Reset  in  1  asynchronous, active-low reset.
- Btn_n  in  N_BTN  raw push-button levels, active-low, asynchronous to Clk.
- Btn_Level  out  N_BTN  debounced level, active-high (1 = pressed).
- Btn_Press  out  N_BTN  one-cycle pulse on each accepted press.
- Btn_Release  out  N_BTN  one-cycle pulse on each accepted release.
- Any_Press  out  1  OR of Btn_Press, same cycle.

Behaviour:
- Input path: per channel, invert Btn_n, then pass through SYNC_STAGES flops. Only the last stage (s) is used by the FSM.
- Per-channel FSM with states IDLE, PRESS_WAIT, HELD, REL_WAIT and a counter cnt of width $clog2(DEBOUNCE_CYCLES+1):
  - IDLE: if s=1, go to PRESS_WAIT with cnt=0.
  - PRESS_WAIT: if s=0, go to IDLE (glitch rejected, no pulse). Otherwise cnt++. When cnt==DEBOUNCE_CYCLES-1 with s=1, go to HELD, set Level=1, and pulse Press.
  - HELD: if s=1, stay. If s=0, go to REL_WAIT with cnt=0.
  - REL_WAIT: if s=1, go to HELD (bounce rejected, no pulse, no Press). Otherwise cnt++. When cnt==DEBOUNCE_CYCLES-1 with s=0, go to IDLE, set Level=0, and pulse Release.
- Latency: count the edge that first samples a new raw level as edge 0. For a level stable from then on:
  - Btn_Press or Btn_Release is high for exactly one cycle after edge SYNC_STAGES+DEBOUNCE_CYCLES.
  - Btn_Level changes on that same edge.
  - With defaults: edge 6.
- All outputs are registered; Any_Press is the registered OR, aligned with Btn_Press.
- Press and Release are never both high on the same channel in one cycle.
- A new pulse on a channel is separated from the previous one by at least DEBOUNCE_CYCLES+1 cycles.
- Channels are fully independent. Simultaneous presses produce pulses in the same cycle.
- Reset=0 (asynchronous, any time, including mid-count): immediately clears all sync flops to 0 (released), all FSMs to IDLE, cnt=0, and Level/Press/Release/Any_Press to 0. Any partially debounced event is dropped with no pulse.
- Release of reset with a button held: treated as a fresh press, giving a Press pulse at edge SYNC_STAGES+DEBOUNCE_CYCLES after the first post-reset edge.
- cnt never wraps: it is cleared on every state entry and bounded by DEBOUNCE_CYCLES-1.
- Requirements on the processor side: Btn_Press is the only edge-type signal. The processor must not re-edge-detect Btn_Level.

Test Plan (defaults: SYNC_STAGES=2, DEBOUNCE_CYCLES=4):
- Reset held low with Btn_n=4'b0000, then released -> all outputs 0 during reset; after edge 6 post-release, Btn_Press=4'hF for 1 cycle, Any_Press=1, Btn_Level=4'hF held.
- Btn_N=4'b1101 from edge 0, held -> Btn_Press=4'b0010 only after edge 6, 0 after edge 7; Btn_Level=4'b0010 from edge 6.
- Btn_n[2] low for 3 cycles then high -> no Press, no Release, Btn_Level stays 4'h0 for 20 cycles.
- Channel 0 held, then release with bounce (high 2 cycles, low 1, high stable) -> no pulse during bounce; Btn_Release[0] pulses once, 6 edges after the final rising raw edge; Btn_Level[0]=0 from then on.
- Press on channel 3, then Reset=0 asynchronously at edge 4 (mid PRESS_WAIT) -> outputs 0 without waiting for a clock edge; no Press pulse while in reset.
- Channel 1 pressed at edge 0 and channel 3 at edge 2 -> Btn_Press[1] after edge 6 and Btn_Press[3] after edge 8, each 1 cycle; Any_Press high in both cycles.
